// File: rtl/qpimem_arb_pkg.sv
// Shared types and widths for the QPI memory arbiter.
package qpimem_arb_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  // Request payload presented to the memory controller.
  typedef struct packed {
    logic              do_read;
    logic              do_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } qpi_req_t;

endpackage

// File: rtl/qpimem_arb_rr.sv
// Combinational pointer-based picker: first requester after last_grant.
// QPIMEM_ARB_PRIO0_EN: master 0 wins whenever it requests.
module qpimem_arb_rr
  import qpimem_arb_pkg::*;
#(
  parameter  int unsigned MASTERS = 3,
  localparam int unsigned IDX_W   = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // Scan from last_grant+1 with wrap; first requester wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      cand = IDX_W'((32'(last_grant_i) + k) % MASTERS);
      if (!valid_o && req_i[cand]) begin
        grant_o = cand;
        valid_o = 1'b1;
      end
    end
`ifdef QPIMEM_ARB_PRIO0_EN
    if (req_i[0]) begin
      grant_o = '0;
      valid_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/qpimem_arbiter.sv
// Shares one QPI memory controller between MASTERS requesters.
// Round-robin by default; QPIMEM_ARB_PRIO0_EN gives master 0 absolute priority.
module qpimem_arbiter
  import qpimem_arb_pkg::*;
#(
  parameter int unsigned MASTERS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MASTERS-1:0]        m_do_read,
  input  logic [MASTERS-1:0]        m_do_write,
  input  logic [MASTERS*ADDR_W-1:0] m_addr,
  input  logic [MASTERS*DATA_W-1:0] m_wdata,
  output logic [MASTERS*DATA_W-1:0] m_rdata,
  output logic [MASTERS-1:0]        m_next_byte,
  output logic [MASTERS-1:0]        m_is_idle,
  output logic                      qpi_do_read,
  output logic                      qpi_do_write,
  output logic [ADDR_W-1:0]         qpi_addr,
  output logic [DATA_W-1:0]         qpi_wdata,
  input  logic [DATA_W-1:0]         qpi_rdata,
  input  logic                      qpi_next_byte,
  input  logic                      qpi_is_idle
);

  localparam int unsigned IDX_W = $clog2(MASTERS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  qpi_req_t         sel;

  qpimem_arb_rr #(
    .MASTERS(MASTERS)
  ) u_rr (
    .req_i       (m_do_read | m_do_write),
    .last_grant_i(last_q),
    .grant_o     (pick),
    .valid_o     (pick_valid)
  );

  // Granted master's request payload.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel.do_read  = m_do_read[i];
        sel.do_write = m_do_write[i];
        sel.addr     = m_addr[i*ADDR_W +: ADDR_W];
        sel.wdata    = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state and muxing; reset kills outstanding memory requests immediately.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    qpi_do_read  = 1'b0;
    qpi_do_write = 1'b0;
    qpi_addr     = '0;
    qpi_wdata    = '0;
    m_next_byte  = '0;
    m_is_idle    = '0;
    m_rdata      = {MASTERS{qpi_rdata}};

    unique case (state_q)
      ST_IDLE: begin
        m_is_idle = {MASTERS{qpi_is_idle}};
        if (qpi_is_idle && pick_valid) begin
          grant_d = pick;
          last_d  = pick;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        qpi_do_read           = sel.do_read;
        qpi_do_write          = sel.do_write;
        qpi_addr              = sel.addr;
        qpi_wdata             = sel.wdata;
        m_next_byte[grant_q]  = qpi_next_byte;
        m_is_idle[grant_q]    = qpi_is_idle;
        if (!sel.do_read && !sel.do_write) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        qpi_addr              = sel.addr;
        qpi_wdata             = sel.wdata;
        m_next_byte[grant_q]  = qpi_next_byte;
        m_is_idle[grant_q]    = qpi_is_idle;
        if (qpi_is_idle) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      qpi_do_read  = 1'b0;
      qpi_do_write = 1'b0;
      qpi_addr     = '0;
      qpi_wdata    = '0;
      m_next_byte  = '0;
    end
  end

endmodule

// File: tb/tb_qpimem_arbiter.sv
// Directed self-checking bench for qpimem_arbiter (MASTERS=3).
module tb_qpimem_arbiter;

  localparam int unsigned M = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  m_do_read, m_do_write;
  logic [M*24-1:0] m_addr;
  logic [M*32-1:0] m_wdata;
  logic [M*32-1:0] m_rdata;
  logic [M-1:0]  m_next_byte, m_is_idle;
  logic          qpi_do_read, qpi_do_write;
  logic [23:0]   qpi_addr;
  logic [31:0]   qpi_wdata, qpi_rdata;
  logic          qpi_next_byte, qpi_is_idle;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  qpimem_arbiter #(.MASTERS(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_do_read    (m_do_read),
    .m_do_write   (m_do_write),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_next_byte  (m_next_byte),
    .m_is_idle    (m_is_idle),
    .qpi_do_read  (qpi_do_read),
    .qpi_do_write (qpi_do_write),
    .qpi_addr     (qpi_addr),
    .qpi_wdata    (qpi_wdata),
    .qpi_rdata    (qpi_rdata),
    .qpi_next_byte(qpi_next_byte),
    .qpi_is_idle  (qpi_is_idle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_do_read = '0;
    m_do_write = '0;
    qpi_next_byte = 1'b0;
    qpi_is_idle = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete burst starting in an IDLE cycle; returns what was observed.
  task automatic do_burst(input logic [2:0] rd, input logic [2:0] wr,
                          output int got, output logic [23:0] addr,
                          output logic [31:0] wd, output logic pre_act,
                          output logic act_rd, output logic act_wr,
                          output logic [23:0] idle_addr);
    m_do_read = rd;
    m_do_write = wr;
    qpi_next_byte = 1'b1;
    qpi_is_idle = 1'b1;
    settle();
    pre_act = qpi_do_read | qpi_do_write;
    idle_addr = qpi_addr;
    step();
    settle();
    got = -1;
    for (int i = 0; i < 3; i++) if (m_next_byte == 3'(1 << i)) got = i;
    addr = qpi_addr;
    wd = qpi_wdata;
    act_rd = qpi_do_read;
    act_wr = qpi_do_write;
    step();
    m_do_read = '0;
    m_do_write = '0;
    qpi_next_byte = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_do_read = 3'b001;
    m_do_write = '0;
    qpi_next_byte = 1'b1;
    qpi_is_idle = 1'b1;
    qpi_rdata = 32'hCAFE_F00D;
    step();
    step();
    settle();
    n_total++; if (qpi_do_read !== 1'b0) $display("FAIL reset_do_read: got %b expected 0", qpi_do_read); else n_pass++;
    n_total++; if (qpi_addr !== 24'h0) $display("FAIL reset_addr: got %h expected 000000", qpi_addr); else n_pass++;
    n_total++; if (m_next_byte !== 3'b000) $display("FAIL reset_next_byte: got %b expected 000", m_next_byte); else n_pass++;
    n_total++; if (m_rdata[32 +: 32] !== 32'hCAFE_F00D) $display("FAIL rdata_bcast: got %h expected cafef00d", m_rdata[32 +: 32]); else n_pass++;
    step();
    rst = 1'b0;
    m_do_read = '0;
    qpi_next_byte = 1'b0;
    settle();
    n_total++; if (m_is_idle !== 3'b111) $display("FAIL reset_is_idle: got %b expected 111", m_is_idle); else n_pass++;
    step();
  endtask

  task automatic test_round_robin();
    int got; logic [23:0] a, ia; logic [31:0] wd; logic pa, ar, aw;
    apply_reset();
    do_burst(3'b111, 3'b000, got, a, wd, pa, ar, aw, ia);
    n_total++; if (pa !== 1'b0) $display("FAIL rr_decision_cycle: got %b expected 0", pa); else n_pass++;
    n_total++; if (got !== 0) $display("FAIL rr_grant0: got %0d expected 0", got); else n_pass++;
    n_total++; if (a !== 24'h000012 || ar !== 1'b1) $display("FAIL rr_addr0: got %h/%b expected 000012/1", a, ar); else n_pass++;
    do_burst(3'b110, 3'b000, got, a, wd, pa, ar, aw, ia);
    n_total++; if (ia !== 24'h0) $display("FAIL rr_idle_addr: got %h expected 000000", ia); else n_pass++;
    n_total++; if (got !== 1) $display("FAIL rr_grant1: got %0d expected 1", got); else n_pass++;
    n_total++; if (a !== 24'h000034) $display("FAIL rr_addr1: got %h expected 000034", a); else n_pass++;
    do_burst(3'b100, 3'b000, got, a, wd, pa, ar, aw, ia);
    n_total++; if (got !== 2) $display("FAIL rr_grant2: got %0d expected 2", got); else n_pass++;
    n_total++; if (a !== 24'h000056) $display("FAIL rr_addr2: got %h expected 000056", a); else n_pass++;
  endtask

  task automatic test_write();
    int got; logic [23:0] a, ia; logic [31:0] wd; logic pa, ar, aw;
    m_addr[24 +: 24] = 24'h000040;
    m_wdata[32 +: 32] = 32'h1234_5678;
    do_burst(3'b000, 3'b010, got, a, wd, pa, ar, aw, ia);
    n_total++; if (pa !== 1'b0) $display("FAIL wr_decision_cycle: got %b expected 0", pa); else n_pass++;
    n_total++; if (aw !== 1'b1 || ar !== 1'b0) $display("FAIL wr_strobes: got wr=%b rd=%b expected wr=1 rd=0", aw, ar); else n_pass++;
    n_total++; if (wd !== 32'h1234_5678) $display("FAIL wr_wdata: got %h expected 12345678", wd); else n_pass++;
    n_total++; if (a !== 24'h000040) $display("FAIL wr_addr: got %h expected 000040", a); else n_pass++;
    n_total++; if (got !== 1) $display("FAIL wr_next_byte_owner: got %0d expected 1", got); else n_pass++;
    m_addr[24 +: 24] = 24'h000034;
  endtask

  task automatic test_rw_both();
    int got; logic [23:0] a, ia; logic [31:0] wd; logic pa, ar, aw;
    do_burst(3'b100, 3'b100, got, a, wd, pa, ar, aw, ia);
    n_total++; if (ar !== 1'b1 || aw !== 1'b1) $display("FAIL rw_both: got rd=%b wr=%b expected 1/1", ar, aw); else n_pass++;
  endtask

  task automatic test_fairness();
    int got; logic [23:0] a, ia; logic [31:0] wd; logic pa, ar, aw;
    logic [2:0] req_tab [6];
    int exp_tab [6];
    req_tab = '{3'b111, 3'b110, 3'b101, 3'b111, 3'b110, 3'b101};
    exp_tab = '{0, 1, 2, 0, 1, 2};
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      do_burst(req_tab[b], 3'b000, got, a, wd, pa, ar, aw, ia);
      n_total++; if (got !== exp_tab[b]) $display("FAIL fair_burst%0d: got %0d expected %0d", b, got, exp_tab[b]); else n_pass++;
    end
  endtask

  task automatic test_prio();
    int got; logic [23:0] a, ia; logic [31:0] wd; logic pa, ar, aw;
    int exp_m;
    apply_reset();
    for (int b = 0; b < 4; b++) begin
`ifdef QPIMEM_ARB_PRIO0_EN
      exp_m = 0;
`else
      exp_m = (b % 2 == 0) ? 0 : 2;
`endif
      do_burst(3'b101, 3'b000, got, a, wd, pa, ar, aw, ia);
      n_total++; if (got !== exp_m) $display("FAIL prio_burst%0d: got %0d expected %0d", b, got, exp_m); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_addr[24 +: 24] = 24'hAAAAAA;
    m_do_read = 3'b010;
    step();
    settle();
    n_total++; if (qpi_do_read !== 1'b1 || qpi_addr !== 24'hAAAAAA) $display("FAIL rstmid_active: got %b/%h expected 1/aaaaaa", qpi_do_read, qpi_addr); else n_pass++;
    step();
    rst = 1'b1;
    qpi_is_idle = 1'b0;
    step();
    rst = 1'b0;
    qpi_next_byte = 1'b1;
    settle();
    n_total++; if (qpi_do_read !== 1'b0) $display("FAIL rstmid_dropped: got %b expected 0", qpi_do_read); else n_pass++;
    n_total++; if (m_next_byte !== 3'b000) $display("FAIL rstmid_next_byte: got %b expected 000", m_next_byte); else n_pass++;
    step();
    settle();
    n_total++; if (qpi_do_read !== 1'b0) $display("FAIL rstmid_busy_no_grant: got %b expected 0", qpi_do_read); else n_pass++;
    step();
    qpi_is_idle = 1'b1;
    qpi_next_byte = 1'b0;
    settle();
    n_total++; if (m_is_idle !== 3'b111 || qpi_do_read !== 1'b0) $display("FAIL rstmid_idle: got %b/%b expected 111/0", m_is_idle, qpi_do_read); else n_pass++;
    step();
    settle();
    n_total++; if (qpi_do_read !== 1'b1 || qpi_addr !== 24'hAAAAAA) $display("FAIL rstmid_regrant: got %b/%h expected 1/aaaaaa", qpi_do_read, qpi_addr); else n_pass++;
    step();
    m_do_read = '0;
    step();
    step();
    m_addr[24 +: 24] = 24'h000034;
  endtask

  task automatic test_drain();
    apply_reset();
    m_do_read = 3'b011;
    step();
    qpi_is_idle = 1'b0;
    settle();
    n_total++; if (qpi_addr !== 24'h000012) $display("FAIL drain_first_owner: got %h expected 000012", qpi_addr); else n_pass++;
    step();
    m_do_read = 3'b010;
    settle();
    n_total++; if (qpi_do_read !== 1'b0) $display("FAIL drain_drop: got %b expected 0", qpi_do_read); else n_pass++;
    step();
    qpi_next_byte = 1'b1;
    settle();
    n_total++; if (m_next_byte !== 3'b001 || m_is_idle !== 3'b000) $display("FAIL drain_strobes: got nb=%b idle=%b expected 001/000", m_next_byte, m_is_idle); else n_pass++;
    step();
    settle();
    n_total++; if (qpi_do_read !== 1'b0) $display("FAIL drain_hold: got %b expected 0", qpi_do_read); else n_pass++;
    step();
    qpi_is_idle = 1'b1;
    qpi_next_byte = 1'b0;
    settle();
    n_total++; if (m_is_idle !== 3'b001 || qpi_do_read !== 1'b0) $display("FAIL drain_exit_cycle: got %b/%b expected 001/0", m_is_idle, qpi_do_read); else n_pass++;
    step();
    settle();
    n_total++; if (m_is_idle !== 3'b111 || qpi_do_read !== 1'b0) $display("FAIL drain_back_idle: got %b/%b expected 111/0", m_is_idle, qpi_do_read); else n_pass++;
    step();
    settle();
    n_total++; if (qpi_do_read !== 1'b1 || qpi_addr !== 24'h000034) $display("FAIL drain_next_grant: got %b/%h expected 1/000034", qpi_do_read, qpi_addr); else n_pass++;
    step();
    m_do_read = '0;
    step();
    step();
  endtask

  initial begin
    m_addr  = {24'h000056, 24'h000034, 24'h000012};
    m_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    qpi_rdata = '0;
    test_reset();
    test_round_robin();
    test_write();
    test_rw_both();
    test_fairness();
    test_prio();
    test_reset_mid();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
